// File: rtl/uart_word_load_ctrl.sv
// Packs UART bytes into big-endian 32-bit words and writes each block to RAM.
// A sentinel word ends a block. The CPU is held in halt until NUM_BLOCKS blocks are stored.
module uart_word_load_ctrl #(
  parameter int          ADDR_W     = 32,
  parameter logic [31:0] BASE_ADDR  = 32'h1000_0000,
  parameter int          MAX_WORDS  = 64,
  parameter logic [31:0] SENTINEL   = 32'd3027,
  parameter int          NUM_BLOCKS = 6,
  parameter int          GAP_CYCLES = 20000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  output logic              mem_req,
  input  logic              mem_ack,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              cpu_halt,
  output logic              load_done,
  output logic [7:0]        blk_count,
  output logic [7:0]        word_count,
  output logic              err_ovf,
  output logic              err_drop,
  output logic              err_gap,
  output logic              dbg_state
);

  // Handshake: mem_req, mem_addr and mem_wdata are held stable while mem_req=1.
  // A write completes on any cycle where mem_req=1 and mem_ack=1.
  // mem_ack is ignored while mem_req=0.
  typedef enum logic {LOAD = 1'b0, DONE = 1'b1} state_e;

  localparam int GAP_W = $clog2(GAP_CYCLES + 1);

  state_e           state, state_next;
  logic [23:0]      asm_q;
  logic [1:0]       byte_cnt;
  logic [GAP_W-1:0] gap_cnt;
  logic [31:0]      word_q;
  logic             word_vld;
  logic             base_pend;
  logic             done_pend;

  logic       accept, gap_timeout, ack_fire, write_busy, disp, is_sent, last_blk, go_done;
  logic [7:0] blk_new;

  function automatic logic [ADDR_W-1:0] blk_base(input logic [7:0] b);
    return ADDR_W'(BASE_ADDR) + ADDR_W'(b) * ADDR_W'(MAX_WORDS * 4);
  endfunction

  // Bytes are refused once the final sentinel is waiting for its last write to drain.
  assign accept      = rx_valid && (state == LOAD) && !done_pend;
  assign gap_timeout = (state == LOAD) && (byte_cnt != 2'd0) && !accept &&
                       (gap_cnt == GAP_W'(GAP_CYCLES - 1));
  assign ack_fire    = mem_req && mem_ack;
  assign write_busy  = mem_req && !mem_ack;
  assign disp        = word_vld && (state == LOAD);
  assign is_sent     = (word_q == SENTINEL);
  assign blk_new     = blk_count + 8'd1;
  assign last_blk    = (blk_new == 8'(NUM_BLOCKS));
  assign go_done     = (disp && is_sent && last_blk && !write_busy) || (ack_fire && done_pend);

  always_comb begin
    state_next = state;
    if (state == LOAD && go_done) state_next = DONE;
  end

  always_ff @(posedge clk) begin
    if (rst) state <= LOAD;
    else     state <= state_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      asm_q      <= '0;
      byte_cnt   <= '0;
      gap_cnt    <= '0;
      word_q     <= '0;
      word_vld   <= 1'b0;
      base_pend  <= 1'b0;
      done_pend  <= 1'b0;
      mem_req    <= 1'b0;
      mem_addr   <= ADDR_W'(BASE_ADDR);
      mem_wdata  <= '0;
      blk_count  <= '0;
      word_count <= '0;
      err_ovf    <= 1'b0;
      err_drop   <= 1'b0;
      err_gap    <= 1'b0;
    end else begin
      if (accept) begin
        asm_q    <= {asm_q[15:0], rx_data};
        byte_cnt <= byte_cnt + 2'd1;
        gap_cnt  <= '0;
      end else if (gap_timeout) begin
        asm_q    <= '0;
        byte_cnt <= '0;
        gap_cnt  <= '0;
        err_gap  <= 1'b1;
      end else if (state == LOAD && byte_cnt != 2'd0) begin
        gap_cnt <= gap_cnt + GAP_W'(1);
      end

      word_vld <= accept && (byte_cnt == 2'd3);
      if (accept && byte_cnt == 2'd3) word_q <= {asm_q, rx_data};

      // A write acked after a sentinel belongs to the previous block.
      // Jump to the new block base and do not count the write.
      if (ack_fire) begin
        mem_req   <= 1'b0;
        done_pend <= 1'b0;
        if (base_pend) begin
          mem_addr  <= blk_base(blk_count);
          base_pend <= 1'b0;
        end else begin
          mem_addr   <= mem_addr + ADDR_W'(4);
          word_count <= word_count + 8'd1;
        end
      end

      if (disp) begin
        if (is_sent) begin
          blk_count  <= blk_new;
          word_count <= '0;
          if (write_busy) begin
            base_pend <= 1'b1;
            done_pend <= last_blk;
          end else begin
            mem_addr <= blk_base(blk_new);
          end
        end else if (word_count == 8'(MAX_WORDS)) begin
          err_ovf <= 1'b1;
        end else if (mem_req) begin
          err_drop <= 1'b1;
        end else begin
          mem_wdata <= word_q;
          mem_req   <= 1'b1;
        end
      end
    end
  end

  assign cpu_halt  = (state == LOAD);
  assign load_done = (state == DONE);
  assign dbg_state = state;

endmodule

// File: tb/tb_uart_word_load_ctrl.sv
// Directed bench for uart_word_load_ctrl.
// Expected RAM writes are queued as {addr, data} and compared against writes seen on the bus.
module tb_uart_word_load_ctrl;
  localparam logic [31:0] BASE = 32'h1000_0000;
  localparam logic [31:0] SENT = 32'd3027;
  localparam int          GAP  = 20000;

  logic        clk = 1'b0;
  logic        rst, rx_valid, mem_ack;
  logic [7:0]  rx_data;
  logic        mem_req, cpu_halt, load_done, err_ovf, err_drop, err_gap, dbg_state;
  logic [31:0] mem_addr, mem_wdata;
  logic [7:0]  blk_count, word_count;

  int checks = 0;
  int failures = 0;
  logic [63:0] exp_q[$];
  logic [63:0] got_q[$];
  logic        saw_req;

  uart_word_load_ctrl dut (
    .clk(clk), .rst(rst), .rx_valid(rx_valid), .rx_data(rx_data),
    .mem_req(mem_req), .mem_ack(mem_ack), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .cpu_halt(cpu_halt), .load_done(load_done), .blk_count(blk_count),
    .word_count(word_count), .err_ovf(err_ovf), .err_drop(err_drop),
    .err_gap(err_gap), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  // Record every completed write on the bus, sampled on the falling edge.
  always @(negedge clk) begin
    if (mem_req && mem_ack) got_q.push_back({mem_addr, mem_wdata});
    if (mem_req) saw_req = 1'b1;
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_data  = b;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) send_byte(w[31-8*i -: 8]);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    rx_valid = 1'b0;
    mem_ack = 1'b0;
    idle(2);
    rst = 1'b0;
    exp_q.delete();
    got_q.delete();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle(2);
    checks++; if (mem_req !== 1'b0) begin failures++; $display("FAIL reset_mem_req got=%0h exp=0", mem_req); end
    checks++; if (mem_addr !== BASE) begin failures++; $display("FAIL reset_mem_addr got=%0h exp=%0h", mem_addr, BASE); end
    checks++; if (mem_wdata !== 32'd0) begin failures++; $display("FAIL reset_mem_wdata got=%0h exp=0", mem_wdata); end
    checks++; if (cpu_halt !== 1'b1) begin failures++; $display("FAIL reset_cpu_halt got=%0h exp=1", cpu_halt); end
    checks++; if (load_done !== 1'b0) begin failures++; $display("FAIL reset_load_done got=%0h exp=0", load_done); end
    checks++; if ({blk_count, word_count} !== 16'd0) begin failures++; $display("FAIL reset_counts got=%0h exp=0", {blk_count, word_count}); end
    checks++; if ({err_ovf, err_drop, err_gap} !== 3'b000) begin failures++; $display("FAIL reset_errs got=%0b exp=000", {err_ovf, err_drop, err_gap}); end
    rst = 1'b0;
  endtask

  task automatic test_basic();
    do_reset();
    mem_ack = 1'b1;
    send_word(32'd238); exp_q.push_back({BASE, 32'd238});
    send_word(32'd74);  exp_q.push_back({BASE + 32'd4, 32'd74});
    idle(3);
    checks++; if (word_count !== 8'd2) begin failures++; $display("FAIL basic_word_count got=%0d exp=2", word_count); end
    send_word(SENT);
    idle(3);
    checks++; if (got_q.size() != exp_q.size()) begin failures++; $display("FAIL basic_nwrites got=%0d exp=%0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++; if (got_q[i] !== exp_q[i]) begin failures++; $display("FAIL basic_write%0d got=%h exp=%h", i, got_q[i], exp_q[i]); end
    end
    checks++; if (blk_count !== 8'd1) begin failures++; $display("FAIL basic_blk_count got=%0d exp=1", blk_count); end
    checks++; if (word_count !== 8'd0) begin failures++; $display("FAIL basic_word_count_after got=%0d exp=0", word_count); end
    checks++; if (mem_addr !== 32'h1000_0100) begin failures++; $display("FAIL basic_mem_addr got=%h exp=10000100", mem_addr); end
    checks++; if (cpu_halt !== 1'b1) begin failures++; $display("FAIL basic_cpu_halt got=%0h exp=1", cpu_halt); end
  endtask

  task automatic test_stall();
    logic [31:0] a, b;
    a = 32'h1122_3344;
    b = 32'h5566_7788;
    do_reset();
    send_word(a);
    idle(1);
    for (int i = 0; i < 10; i++) begin
      checks++;
      if ({mem_req, mem_addr, mem_wdata} !== {1'b1, BASE, a}) begin
        failures++; $display("FAIL stall_hold%0d got=%0h/%h/%h exp=1/%h/%h", i, mem_req, mem_addr, mem_wdata, BASE, a);
      end
      if (i < 4) begin rx_valid = 1'b1; rx_data = b[31-8*i -: 8]; end
      else rx_valid = 1'b0;
      @(negedge clk);
    end
    checks++; if (err_drop !== 1'b1) begin failures++; $display("FAIL stall_err_drop got=%0h exp=1", err_drop); end
    mem_ack = 1'b1;
    exp_q.push_back({BASE, a});
    idle(3);
    checks++; if (got_q.size() != exp_q.size()) begin failures++; $display("FAIL stall_nwrites got=%0d exp=%0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++; if (got_q[i] !== exp_q[i]) begin failures++; $display("FAIL stall_write%0d got=%h exp=%h", i, got_q[i], exp_q[i]); end
    end
    checks++; if (word_count !== 8'd1) begin failures++; $display("FAIL stall_word_count got=%0d exp=1", word_count); end
  endtask

  task automatic test_ovf();
    do_reset();
    mem_ack = 1'b1;
    for (int i = 0; i < 65; i++) begin
      send_word(32'(i + 1));
      if (i < 64) exp_q.push_back({BASE + 32'(4 * i), 32'(i + 1)});
    end
    idle(3);
    checks++; if (err_ovf !== 1'b1) begin failures++; $display("FAIL ovf_err got=%0h exp=1", err_ovf); end
    checks++; if (word_count !== 8'd64) begin failures++; $display("FAIL ovf_word_count got=%0d exp=64", word_count); end
    send_word(SENT);
    idle(3);
    checks++; if (blk_count !== 8'd1) begin failures++; $display("FAIL ovf_blk_count got=%0d exp=1", blk_count); end
    checks++; if (mem_addr !== 32'h1000_0100) begin failures++; $display("FAIL ovf_mem_addr got=%h exp=10000100", mem_addr); end
    send_word(32'h77);
    exp_q.push_back({32'h1000_0100, 32'h77});
    idle(3);
    checks++; if (got_q.size() != exp_q.size()) begin failures++; $display("FAIL ovf_nwrites got=%0d exp=%0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++; if (got_q[i] !== exp_q[i]) begin failures++; $display("FAIL ovf_write%0d got=%h exp=%h", i, got_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_gap();
    do_reset();
    mem_ack = 1'b1;
    // A byte arriving on the timeout edge is kept.
    send_byte(8'h01);
    idle(GAP - 1);
    send_byte(8'h02); send_byte(8'h03); send_byte(8'h04);
    exp_q.push_back({BASE, 32'h0102_0304});
    idle(3);
    checks++; if (err_gap !== 1'b0) begin failures++; $display("FAIL gap_edge_err got=%0h exp=0", err_gap); end
    send_byte(8'hAA); send_byte(8'hBB);
    idle(GAP);
    checks++; if (err_gap !== 1'b1) begin failures++; $display("FAIL gap_timeout_err got=%0h exp=1", err_gap); end
    send_word(32'd5);
    exp_q.push_back({BASE + 32'd4, 32'd5});
    idle(3);
    checks++; if (got_q.size() != exp_q.size()) begin failures++; $display("FAIL gap_nwrites got=%0d exp=%0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++; if (got_q[i] !== exp_q[i]) begin failures++; $display("FAIL gap_write%0d got=%h exp=%h", i, got_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    send_word(32'hDEAD_0001);
    idle(1);
    checks++; if (mem_req !== 1'b1) begin failures++; $display("FAIL rstmid_pre_req got=%0h exp=1", mem_req); end
    send_byte(8'hAB); send_byte(8'hCD);
    rst = 1'b1;
    @(negedge clk);
    checks++; if (mem_req !== 1'b0) begin failures++; $display("FAIL rstmid_mem_req got=%0h exp=0", mem_req); end
    checks++; if ({mem_addr, mem_wdata} !== {BASE, 32'd0}) begin failures++; $display("FAIL rstmid_addr_data got=%h exp=%h", {mem_addr, mem_wdata}, {BASE, 32'd0}); end
    checks++; if ({cpu_halt, load_done, blk_count, word_count} !== {2'b10, 16'd0}) begin failures++; $display("FAIL rstmid_status got=%h exp=%h", {cpu_halt, load_done, blk_count, word_count}, {2'b10, 16'd0}); end
    rst = 1'b0;
    mem_ack = 1'b1;
    got_q.delete();
    send_word(32'h99);
    exp_q.push_back({BASE, 32'h99});
    idle(3);
    checks++; if (got_q.size() != exp_q.size()) begin failures++; $display("FAIL rstmid_nwrites got=%0d exp=%0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++; if (got_q[i] !== exp_q[i]) begin failures++; $display("FAIL rstmid_write%0d got=%h exp=%h", i, got_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_full_load();
    logic [31:0] w;
    do_reset();
    mem_ack = 1'b1;
    for (int b = 0; b < 6; b++) begin
      for (int i = 0; i < 44; i++) begin
        w = 32'h0A00_0000 | 32'(b << 8) | 32'(i);
        send_word(w);
        exp_q.push_back({BASE + 32'(b * 256) + 32'(i * 4), w});
      end
      send_word(SENT);
      if (b < 5) idle(1);
    end
    checks++; if ({cpu_halt, load_done} !== 2'b10) begin failures++; $display("FAIL full_pre_done got=%b exp=10", {cpu_halt, load_done}); end
    idle(1);
    checks++; if ({cpu_halt, load_done, dbg_state} !== 3'b011) begin failures++; $display("FAIL full_done got=%b exp=011", {cpu_halt, load_done, dbg_state}); end
    idle(2);
    checks++; if (got_q.size() != exp_q.size()) begin failures++; $display("FAIL full_nwrites got=%0d exp=%0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++; if (got_q[i] !== exp_q[i]) begin failures++; $display("FAIL full_write%0d got=%h exp=%h", i, got_q[i], exp_q[i]); end
    end
    checks++; if (exp_q[263] !== {32'h1000_05AC, 32'h0A00_052B}) begin failures++; $display("FAIL full_last_exp got=%h", exp_q[263]); end
    checks++; if (blk_count !== 8'd6) begin failures++; $display("FAIL full_blk_count got=%0d exp=6", blk_count); end
    saw_req = 1'b0;
    send_word(32'h1234);
    idle(4);
    checks++; if (saw_req !== 1'b0) begin failures++; $display("FAIL full_rx_ignored got=%0h exp=0", saw_req); end
    checks++; if ({load_done, cpu_halt, blk_count, word_count} !== {2'b10, 8'd6, 8'd0}) begin failures++; $display("FAIL full_frozen got=%h exp=%h", {load_done, cpu_halt, blk_count, word_count}, {2'b10, 8'd6, 8'd0}); end
  endtask

  initial begin
    rst = 1'b1;
    rx_valid = 1'b0;
    rx_data = 8'h00;
    mem_ack = 1'b0;
    saw_req = 1'b0;
    idle(2);
    test_reset();
    test_basic();
    test_stall();
    test_ovf();
    test_gap();
    test_reset_mid();
    test_full_load();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/uart_word_load_ctrl.md
Name: uart_word_load_ctrl

Overview:
Download sequencer between the UART receiver and data RAM of the RISC-V SoC. It takes received bytes, assembles big-endian 32-bit words (MSB byte first, as the host sends them), and writes them to consecutive RAM addresses. A sentinel word terminates each block. The CPU is held in halt until NUM_BLOCKS blocks have been stored.

Parameters:
ADDR_W, 32, RAM address width (byte address)
BASE_ADDR, 32'h1000_0000, byte address of block 0 word 0
MAX_WORDS, 64, word slots per block; block b base = BASE_ADDR + b*MAX_WORDS*4
SENTINEL, 32'd3027, block terminator word, never written to RAM
NUM_BLOCKS, 6, blocks to load before releasing the CPU
GAP_CYCLES, 20000, max idle clocks between bytes of one word before the partial word is discarded

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
rx_valid  in  1  one-cycle strobe: rx_data holds a received byte
rx_data  in  8  received byte
mem_req  out  1  write request, held until mem_ack
mem_ack  in  1  RAM accepted write this cycle
mem_addr  out  ADDR_W  word-aligned byte address
mem_wdata  out  32  write data
cpu_halt  out  1  hold CPU pipeline/PC
load_done  out  1  all blocks loaded (sticky)
blk_count  out  8  completed blocks
word_count  out  8  words written in current block
err_ovf  out  1  sticky: block exceeded MAX_WORDS
err_drop  out  1  sticky: word completed while previous write still pending
err_gap  out  1  sticky: partial word discarded on gap timeout

Behaviour:
- Reset values: mem_req=0, mem_addr=BASE_ADDR, mem_wdata=0, cpu_halt=1, load_done=0, blk_count=0, word_count=0, all err_*=0, byte_cnt=0, gap counter=0, state=LOAD.
- States: LOAD (assembling/writing) and DONE.
- Assembly (LOAD): on rx_valid, asm <= {asm[23:0], rx_data} and byte_cnt++. The 4th byte completes word W = {asm[23:0], rx_data}. byte_cnt wraps to 0.
- Word dispatch (the cycle after completion):
  - W==SENTINEL: blk_count++ and word_count<=0. mem_addr <= BASE_ADDR + blk_count_new*MAX_WORDS*4. If blk_count_new==NUM_BLOCKS, go to DONE. No write is issued.
  - Otherwise, if word_count==MAX_WORDS: discard W and set err_ovf. This continues until the sentinel arrives.
  - Otherwise, if mem_req==1 (prior write unacknowledged): discard W and set err_drop.
  - Otherwise: mem_wdata<=W and mem_req<=1, with mem_addr as currently held.
- Write handshake: mem_req, mem_addr and mem_wdata stay stable until a cycle with mem_ack=1. On the next edge: mem_req<=0, mem_addr+=4, word_count++. mem_ack while mem_req=0 is ignored.
- Assembly continues during a pending write. Write data is held in a separate register from the assembly register.
- Gap timer:
  - Counts only while byte_cnt!=0 and cleared on every rx_valid.
  - On reaching GAP_CYCLES: byte_cnt<=0, asm discarded, err_gap set.
  - A byte arriving in the same cycle as the timeout wins: the byte is accepted and the timer is cleared.
- Sentinel while a write is pending: the block-base update of mem_addr is deferred until that write's ack.
- Transition to DONE waits for any pending write to complete. In DONE: cpu_halt=0 and load_done=1 from the first DONE cycle. rx_valid is ignored. Counters are frozen.
- Reset mid-operation: all state returns to reset values on the next edge, including the partial word and a pending request (mem_req drops immediately). RAM contents are not touched.
- blk_count and word_count wrap modulo 256. This is unreachable with legal parameters, which require NUM_BLOCKS<=255 and MAX_WORDS<=255.

Test Plan:
- Send bytes 00 00 00 EE, 00 00 00 4A, then sentinel 00 00 0B D3, with mem_ack tied 1 → writes 238@0x1000_0000 and 74@0x1000_0004; after sentinel blk_count=1, word_count=0, mem_addr=0x1000_0100; cpu_halt stays 1.
- Six blocks of 44 words each plus sentinel (host stream pattern) → 264 writes, last at 0x1000_0500+0xAC; load_done=1 and cpu_halt=0 one cycle after the 6th sentinel; later rx_valid produces no mem_req.
- Hold mem_ack=0 for 10 cycles → mem_req/addr/wdata stable for all 10 cycles; a word completing meanwhile sets err_drop and is not written.
- Send 65 non-sentinel words into one block → 64 writes; err_ovf=1; 65th word discarded; following sentinel advances normally to block 1.
- Send 2 bytes then idle GAP_CYCLES clocks, then 00 00 00 05 → err_gap=1; value 5 written (stale bytes discarded).
- Assert rst mid-word with mem_req=1 → next cycle all outputs at reset values; a following clean word is written at 0x1000_0000.
